// File: rtl/uart_tx_scheduler_if.sv
// Bundles the scheduler's APB-side, flow-control and transmitter-side signals.
// master drives the inputs and observes the outputs; slave is the scheduler itself.
interface uart_tx_scheduler_if #(
    parameter int DEPTH = 16
);
    localparam int LW = $clog2(DEPTH) + 1;

    logic          wr_en_i;
    logic [7:0]    wr_data_i;
    logic          flush_i;
    logic          tx_en_i;
    logic          cts_ni;
    logic          tick_i;
    logic          xon_req_i;
    logic          xoff_req_i;
    logic          trans_fi_i;
    logic          start_tx_o;
    logic [7:0]    data_o;
    logic          busy_o;
    logic [LW-1:0] fifo_level_o;
    logic          fifo_full_o;
    logic          fifo_empty_o;
    logic          overflow_o;
    logic          timeout_o;

    modport master (
        output wr_en_i, wr_data_i, flush_i, tx_en_i, cts_ni, tick_i,
               xon_req_i, xoff_req_i, trans_fi_i,
        input  start_tx_o, data_o, busy_o, fifo_level_o, fifo_full_o,
               fifo_empty_o, overflow_o, timeout_o
    );

    modport slave (
        input  wr_en_i, wr_data_i, flush_i, tx_en_i, cts_ni, tick_i,
               xon_req_i, xoff_req_i, trans_fi_i,
        output start_tx_o, data_o, busy_o, fifo_level_o, fifo_full_o,
               fifo_empty_o, overflow_o, timeout_o
    );
endinterface

// File: rtl/uart_tx_scheduler.sv
// UART TX scheduler: TX FIFO plus XON/XOFF injection, launching one frame at a time
// to the transmitter and enforcing a watchdog and an inter-frame gap.
module uart_tx_scheduler #(
    parameter int         DEPTH      = 16,
    parameter int         GAP_TICKS  = 0,
    parameter int         FI_TIMEOUT = 4095,
    parameter logic [7:0] XON_CHAR   = 8'h11,
    parameter logic [7:0] XOFF_CHAR  = 8'h13
) (
    input logic              clk,
    input logic              reset_n,
    uart_tx_scheduler_if.slave bus
);
    localparam int AW  = $clog2(DEPTH);
    localparam int LW  = AW + 1;
    localparam int WDW = (FI_TIMEOUT > 1) ? $clog2(FI_TIMEOUT) : 1;
    localparam logic [WDW-1:0] WD_LAST  = (FI_TIMEOUT == 0) ? '0 : WDW'(FI_TIMEOUT - 1);
    localparam logic [3:0]     GAP_LAST = (GAP_TICKS == 0) ? 4'd0 : 4'(GAP_TICKS - 1);

    typedef enum logic [2:0] {
        IDLE,
        LOAD,
        START,
        WAIT_FI,
        GAP
    } state_e;

    state_e         state_q, state_d;
    logic [7:0]     mem_q [DEPTH];
    logic [AW-1:0]  wrPtr_q, rdPtr_q;
    logic [LW-1:0]  level_q, level_d;
    logic           ctrlPend_q, ctrlPend_d;
    logic           ctrlXoff_q, ctrlXoff_d;
    logic [7:0]     data_q, data_d;
    logic [WDW-1:0] wdCnt_q, wdCnt_d;
    logic [3:0]     gapCnt_q, gapCnt_d;
    logic           overflow_q, overflow_d;
    logic           timeout_q, timeout_d;
    logic           fifoEmpty, fifoFull, pop, wrAccept;

    // A pop frees a slot in the same cycle, so a write to a full FIFO is still taken.
    always_comb begin
        fifoEmpty  = (level_q == '0);
        fifoFull   = (level_q == LW'(DEPTH));
        pop        = (state_q == LOAD) && !ctrlPend_q && !fifoEmpty;
        wrAccept   = bus.wr_en_i && !bus.flush_i && (!fifoFull || pop);
        overflow_d = bus.wr_en_i && !bus.flush_i && fifoFull && !pop;
        level_d    = level_q;
        if (bus.flush_i) begin
            level_d = '0;
        end else if (wrAccept && !pop) begin
            level_d = level_q + LW'(1);
        end else if (pop && !wrAccept) begin
            level_d = level_q - LW'(1);
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            wrPtr_q    <= '0;
            rdPtr_q    <= '0;
            level_q    <= '0;
            overflow_q <= 1'b0;
        end else begin
            level_q    <= level_d;
            overflow_q <= overflow_d;
            if (bus.flush_i) begin
                wrPtr_q <= '0;
                rdPtr_q <= '0;
            end else begin
                if (wrAccept) wrPtr_q <= wrPtr_q + AW'(1);
                if (pop)      rdPtr_q <= rdPtr_q + AW'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (wrAccept) mem_q[wrPtr_q] <= bus.wr_data_i;
    end

    // A new request in the consuming LOAD cycle survives; XOFF beats a same-cycle XON.
    always_comb begin
        ctrlPend_d = ctrlPend_q;
        ctrlXoff_d = ctrlXoff_q;
        if (state_q == LOAD && ctrlPend_q) ctrlPend_d = 1'b0;
        if (bus.xoff_req_i) begin
            ctrlPend_d = 1'b1;
            ctrlXoff_d = 1'b1;
        end else if (bus.xon_req_i) begin
            ctrlPend_d = 1'b1;
            ctrlXoff_d = 1'b0;
        end
    end

    always_comb begin
        state_d   = state_q;
        data_d    = data_q;
        wdCnt_d   = wdCnt_q;
        gapCnt_d  = gapCnt_q;
        timeout_d = 1'b0;
        case (state_q)
            IDLE: begin
                if (bus.tx_en_i && !bus.cts_ni && (ctrlPend_q || !fifoEmpty)) state_d = LOAD;
            end
            LOAD: begin
                // A flush between IDLE and LOAD can leave nothing to send.
                if (ctrlPend_q) begin
                    data_d  = ctrlXoff_q ? XOFF_CHAR : XON_CHAR;
                    state_d = START;
                end else if (!fifoEmpty) begin
                    data_d  = mem_q[rdPtr_q];
                    state_d = START;
                end else begin
                    state_d = IDLE;
                end
            end
            START: begin
                wdCnt_d = '0;
                state_d = WAIT_FI;
            end
            WAIT_FI: begin
                if (bus.trans_fi_i) begin
                    gapCnt_d = '0;
                    state_d  = (GAP_TICKS == 0) ? IDLE : GAP;
                end else if (FI_TIMEOUT != 0 && wdCnt_q == WD_LAST) begin
                    timeout_d = 1'b1;
                    state_d   = IDLE;
                end else begin
                    wdCnt_d = wdCnt_q + WDW'(1);
                end
            end
            GAP: begin
                if (bus.tick_i) begin
                    if (gapCnt_q == GAP_LAST) state_d = IDLE;
                    else                      gapCnt_d = gapCnt_q + 4'd1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q    <= IDLE;
            data_q     <= '0;
            wdCnt_q    <= '0;
            gapCnt_q   <= '0;
            timeout_q  <= 1'b0;
            ctrlPend_q <= 1'b0;
            ctrlXoff_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            data_q     <= data_d;
            wdCnt_q    <= wdCnt_d;
            gapCnt_q   <= gapCnt_d;
            timeout_q  <= timeout_d;
            ctrlPend_q <= ctrlPend_d;
            ctrlXoff_q <= ctrlXoff_d;
        end
    end

    assign bus.start_tx_o   = (state_q == START);
    assign bus.data_o       = data_q;
    assign bus.busy_o       = (state_q != IDLE);
    assign bus.fifo_level_o = level_q;
    assign bus.fifo_full_o  = fifoFull;
    assign bus.fifo_empty_o = fifoEmpty;
    assign bus.overflow_o   = overflow_q;
    assign bus.timeout_o    = timeout_q;
endmodule

// File: tb/tb_uart_tx_scheduler.sv
// Self-checking bench: dut0 (DEPTH=4, no gap, no watchdog) and dut1 (DEPTH=4, GAP=2,
// FI_TIMEOUT=10) share clock and reset.
module tb_uart_tx_scheduler;
    logic clk = 1'b0;
    logic reset_n = 1'b0;
    int testsRun = 0;
    int testsFailed = 0;
    int cycleCnt = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cycleCnt <= cycleCnt + 1;

    uart_tx_scheduler_if #(.DEPTH(4)) bus0 ();
    uart_tx_scheduler_if #(.DEPTH(4)) bus1 ();

    uart_tx_scheduler #(.DEPTH(4), .GAP_TICKS(0), .FI_TIMEOUT(0)) dut0 (
        .clk(clk), .reset_n(reset_n), .bus(bus0)
    );
    uart_tx_scheduler #(.DEPTH(4), .GAP_TICKS(2), .FI_TIMEOUT(10)) dut1 (
        .clk(clk), .reset_n(reset_n), .bus(bus1)
    );

    typedef struct {
        logic       wrEn;
        logic [7:0] wrData;
        logic       flush;
        logic [2:0] expLevel;
        logic       expFull;
        logic       expEmpty;
        logic       expOverflow;
    } fifoVec_t;

    fifoVec_t vecs [10];

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        testsRun++;
        if (actual !== expected) begin
            testsFailed++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic applyStimulus(input fifoVec_t v);
        bus0.wr_en_i   = v.wrEn;
        bus0.wr_data_i = v.wrData;
        bus0.flush_i   = v.flush;
        step();
        bus0.wr_en_i = 1'b0;
        bus0.flush_i = 1'b0;
    endtask

    task automatic writeByte(input int sel, input logic [7:0] d);
        if (sel == 0) begin
            bus0.wr_en_i = 1'b1; bus0.wr_data_i = d;
        end else begin
            bus1.wr_en_i = 1'b1; bus1.wr_data_i = d;
        end
        step();
        bus0.wr_en_i = 1'b0;
        bus1.wr_en_i = 1'b0;
    endtask

    task automatic waitStart(input int sel, input int budget, output bit seen);
        seen = 1'b0;
        for (int i = 0; i < budget; i++) begin
            @(negedge clk);
            if ((sel == 0 && bus0.start_tx_o) || (sel == 1 && bus1.start_tx_o)) begin
                seen = 1'b1;
                break;
            end
        end
    endtask

    task automatic finishFrame(input int sel);
        step();
        if (sel == 0) bus0.trans_fi_i = 1'b1;
        else          bus1.trans_fi_i = 1'b1;
        step();
        bus0.trans_fi_i = 1'b0;
        bus1.trans_fi_i = 1'b0;
    endtask

    task automatic expectFrame(input string name, input logic [7:0] d);
        bit seen;
        waitStart(0, 20, seen);
        checkOutput({name, "_start"}, 32'(seen), 32'd1);
        checkOutput({name, "_data"}, 32'(bus0.data_o), 32'(d));
        finishFrame(0);
    endtask

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] time limit");
    end

    initial begin
        bit seen;
        int tMark;

        vecs[0] = '{1'b1, 8'h10, 1'b0, 3'd1, 1'b0, 1'b0, 1'b0};
        vecs[1] = '{1'b1, 8'h11, 1'b0, 3'd2, 1'b0, 1'b0, 1'b0};
        vecs[2] = '{1'b1, 8'h12, 1'b0, 3'd3, 1'b0, 1'b0, 1'b0};
        vecs[3] = '{1'b1, 8'h13, 1'b0, 3'd4, 1'b1, 1'b0, 1'b0};
        vecs[4] = '{1'b1, 8'h14, 1'b0, 3'd4, 1'b1, 1'b0, 1'b1};
        vecs[5] = '{1'b0, 8'h00, 1'b0, 3'd4, 1'b1, 1'b0, 1'b0};
        vecs[6] = '{1'b1, 8'h15, 1'b1, 3'd0, 1'b0, 1'b1, 1'b0};
        vecs[7] = '{1'b1, 8'h20, 1'b0, 3'd1, 1'b0, 1'b0, 1'b0};
        vecs[8] = '{1'b0, 8'h00, 1'b1, 3'd0, 1'b0, 1'b1, 1'b0};
        vecs[9] = '{1'b0, 8'h00, 1'b0, 3'd0, 1'b0, 1'b1, 1'b0};

        {bus0.wr_en_i, bus0.flush_i, bus0.tx_en_i, bus0.cts_ni, bus0.tick_i} = '0;
        {bus0.xon_req_i, bus0.xoff_req_i, bus0.trans_fi_i, bus0.wr_data_i} = '0;
        {bus1.wr_en_i, bus1.flush_i, bus1.tx_en_i, bus1.cts_ni, bus1.tick_i} = '0;
        {bus1.xon_req_i, bus1.xoff_req_i, bus1.trans_fi_i, bus1.wr_data_i} = '0;

        // Reset values while reset is held.
        repeat (2) @(negedge clk);
        checkOutput("rst_start", 32'(bus0.start_tx_o), 32'd0);
        checkOutput("rst_data", 32'(bus0.data_o), 32'd0);
        checkOutput("rst_busy", 32'(bus0.busy_o), 32'd0);
        checkOutput("rst_level", 32'(bus0.fifo_level_o), 32'd0);
        checkOutput("rst_empty", 32'(bus0.fifo_empty_o), 32'd1);
        checkOutput("rst_full", 32'(bus0.fifo_full_o), 32'd0);
        checkOutput("rst_ovf", 32'(bus0.overflow_o), 32'd0);
        checkOutput("rst_timeout", 32'(bus0.timeout_o), 32'd0);
        checkOutput("rst1_empty", 32'(bus1.fifo_empty_o), 32'd1);
        step();
        reset_n = 1'b1;
        step();

        // FIFO fill / overflow / flush vectors with transmit disabled.
        for (int i = 0; i < 10; i++) begin
            applyStimulus(vecs[i]);
            checkOutput($sformatf("vec%0d_level", i), 32'(bus0.fifo_level_o), 32'(vecs[i].expLevel));
            checkOutput($sformatf("vec%0d_full", i), 32'(bus0.fifo_full_o), 32'(vecs[i].expFull));
            checkOutput($sformatf("vec%0d_empty", i), 32'(bus0.fifo_empty_o), 32'(vecs[i].expEmpty));
            checkOutput($sformatf("vec%0d_ovf", i), 32'(bus0.overflow_o), 32'(vecs[i].expOverflow));
        end

        // Write while popping when full, then drain across the pointer wrap.
        for (int i = 0; i < 4; i++) writeByte(0, 8'hA0 + 8'(i));
        checkOutput("full_before_pop", 32'(bus0.fifo_full_o), 32'd1);
        bus0.tx_en_i = 1'b1;
        step();
        bus0.wr_en_i = 1'b1; bus0.wr_data_i = 8'hA4;
        step();
        bus0.wr_en_i = 1'b0;
        checkOutput("popwr_level", 32'(bus0.fifo_level_o), 32'd4);
        checkOutput("popwr_ovf", 32'(bus0.overflow_o), 32'd0);
        @(negedge clk);
        checkOutput("popwr_start", 32'(bus0.start_tx_o), 32'd1);
        checkOutput("popwr_data", 32'(bus0.data_o), 32'hA0);
        finishFrame(0);
        for (int k = 1; k < 5; k++) expectFrame($sformatf("drain%0d", k), 8'hA0 + 8'(k));

        // Launch latency and back-to-back frames with no gap.
        writeByte(0, 8'h41);
        tMark = cycleCnt;
        writeByte(0, 8'h42);
        waitStart(0, 20, seen);
        checkOutput("lat_start", 32'(seen), 32'd1);
        checkOutput("lat_cycles", 32'(cycleCnt - tMark), 32'd2);
        checkOutput("lat_data", 32'(bus0.data_o), 32'h41);
        step();
        checkOutput("wait_busy", 32'(bus0.busy_o), 32'd1);
        checkOutput("wait_hold", 32'(bus0.data_o), 32'h41);
        bus0.trans_fi_i = 1'b1;
        step();
        bus0.trans_fi_i = 1'b0;
        tMark = cycleCnt;
        waitStart(0, 20, seen);
        checkOutput("b2b_start", 32'(seen), 32'd1);
        checkOutput("b2b_cycles", 32'(cycleCnt - tMark), 32'd2);
        checkOutput("b2b_data", 32'(bus0.data_o), 32'h42);
        finishFrame(0);
        waitStart(0, 6, seen);
        checkOutput("b2b_none", 32'(seen), 32'd0);
        checkOutput("b2b_idle", 32'(bus0.busy_o), 32'd0);

        // Control characters take priority; XOFF wins a tie; later request overwrites.
        bus0.tx_en_i = 1'b0;
        writeByte(0, 8'h55);
        bus0.xoff_req_i = 1'b1; step(); bus0.xoff_req_i = 1'b0;
        bus0.tx_en_i = 1'b1;
        expectFrame("xoff_first", 8'h13);
        expectFrame("after_xoff", 8'h55);
        bus0.xon_req_i = 1'b1; bus0.xoff_req_i = 1'b1; step();
        bus0.xon_req_i = 1'b0; bus0.xoff_req_i = 1'b0;
        expectFrame("tie", 8'h13);
        waitStart(0, 8, seen);
        checkOutput("tie_single", 32'(seen), 32'd0);
        bus0.tx_en_i = 1'b0;
        bus0.xoff_req_i = 1'b1; step(); bus0.xoff_req_i = 1'b0;
        bus0.xon_req_i = 1'b1; step(); bus0.xon_req_i = 1'b0;
        bus0.tx_en_i = 1'b1;
        expectFrame("overwrite", 8'h11);
        waitStart(0, 8, seen);
        checkOutput("overwrite_single", 32'(seen), 32'd0);

        // CTS gating: no launch while high, in-flight frame completes when raised.
        bus0.cts_ni = 1'b1;
        writeByte(0, 8'h66);
        waitStart(0, 8, seen);
        checkOutput("cts_block", 32'(seen), 32'd0);
        bus0.cts_ni = 1'b0;
        waitStart(0, 20, seen);
        checkOutput("cts_go", 32'(seen), 32'd1);
        checkOutput("cts_data", 32'(bus0.data_o), 32'h66);
        step();
        bus0.cts_ni = 1'b1;
        writeByte(0, 8'h67);
        finishFrame(0);
        waitStart(0, 8, seen);
        checkOutput("cts_hold", 32'(seen), 32'd0);
        checkOutput("cts_idle", 32'(bus0.busy_o), 32'd0);
        checkOutput("cts_level", 32'(bus0.fifo_level_o), 32'd1);
        bus0.cts_ni = 1'b0;
        expectFrame("cts_resume", 8'h67);

        // Flush with 3 bytes queued behind an in-flight frame.
        writeByte(0, 8'h70);
        waitStart(0, 20, seen);
        checkOutput("fl_start", 32'(seen), 32'd1);
        step();
        for (int i = 1; i < 4; i++) writeByte(0, 8'h70 + 8'(i));
        checkOutput("fl_level3", 32'(bus0.fifo_level_o), 32'd3);
        bus0.flush_i = 1'b1; step(); bus0.flush_i = 1'b0;
        checkOutput("fl_level0", 32'(bus0.fifo_level_o), 32'd0);
        checkOutput("fl_busy", 32'(bus0.busy_o), 32'd1);
        checkOutput("fl_data", 32'(bus0.data_o), 32'h70);
        finishFrame(0);
        waitStart(0, 8, seen);
        checkOutput("fl_none", 32'(seen), 32'd0);

        // Inter-frame gap of 2 ticks, then watchdog abort on dut1.
        bus1.tx_en_i = 1'b1;
        writeByte(1, 8'h81);
        writeByte(1, 8'h82);
        waitStart(1, 20, seen);
        checkOutput("gap_first", 32'(seen), 32'd1);
        checkOutput("gap_first_data", 32'(bus1.data_o), 32'h81);
        finishFrame(1);
        waitStart(1, 5, seen);
        checkOutput("gap_wait0", 32'(seen), 32'd0);
        bus1.tick_i = 1'b1; step(); bus1.tick_i = 1'b0;
        waitStart(1, 4, seen);
        checkOutput("gap_wait1", 32'(seen), 32'd0);
        bus1.tick_i = 1'b1; step(); bus1.tick_i = 1'b0;
        tMark = cycleCnt;
        waitStart(1, 20, seen);
        checkOutput("gap_second", 32'(seen), 32'd1);
        checkOutput("gap_cycles", 32'(cycleCnt - tMark), 32'd2);
        checkOutput("gap_second_data", 32'(bus1.data_o), 32'h82);
        tMark = cycleCnt;
        seen = 1'b0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (bus1.timeout_o) begin
                seen = 1'b1;
                break;
            end
        end
        checkOutput("to_pulse", 32'(seen), 32'd1);
        checkOutput("to_cycles", 32'(cycleCnt - tMark), 32'd11);
        checkOutput("to_busy", 32'(bus1.busy_o), 32'd0);
        @(negedge clk);
        checkOutput("to_single", 32'(bus1.timeout_o), 32'd0);
        waitStart(1, 8, seen);
        checkOutput("to_no_retry", 32'(seen), 32'd0);

        // Asynchronous reset in WAIT_FI with queued bytes and a pending control char.
        writeByte(0, 8'h90);
        waitStart(0, 20, seen);
        checkOutput("rf_start", 32'(seen), 32'd1);
        step();
        writeByte(0, 8'h91);
        writeByte(0, 8'h92);
        bus0.xoff_req_i = 1'b1; step(); bus0.xoff_req_i = 1'b0;
        reset_n = 1'b0;
        #2;
        checkOutput("rf_busy", 32'(bus0.busy_o), 32'd0);
        checkOutput("rf_data", 32'(bus0.data_o), 32'd0);
        checkOutput("rf_level", 32'(bus0.fifo_level_o), 32'd0);
        checkOutput("rf_empty", 32'(bus0.fifo_empty_o), 32'd1);
        checkOutput("rf_start_low", 32'(bus0.start_tx_o), 32'd0);
        step();
        reset_n = 1'b1;
        waitStart(0, 8, seen);
        checkOutput("rf_none", 32'(seen), 32'd0);

        $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
        $finish;
    end
endmodule
